// File: rtl/apb_uart_tx_fifo.sv
// APB slave UART transmitter: TX FIFO, programmable baud divisor, parity,
// one/two stop bits and a FIFO-level / overflow interrupt.
module apb_uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  output logic              utxd_o,
  output logic              uart_int_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_INTCFG = ADDR_W'(8'h10);
  localparam logic [3:0]        LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Configuration and status registers
  logic             txen, stop2, ovf, lvl_ie, ovf_ie, int_r;
  logic [1:0]       par;
  logic [DIV_W-1:0] div;
  logic [7:0]       thresh;

  // FIFO storage
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          level;
  logic [DATA_BITS-1:0] head;
  logic                 full, empty, push_req, push, ovf_set, pop;

  // Transmitter state and frame-local copies of the configuration
  state_t               state, state_n;
  logic [DIV_W-1:0]     cnt, cnt_n, f_div, f_div_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] sh, sh_n, sh_shift;
  logic                 f_par_en, f_par_en_n, f_par_bit, f_par_bit_n;
  logic                 f_stop2, f_stop2_n, stop_cnt, stop_cnt_n;
  logic                 utxd, utxd_n, load;

  logic wr_en, rd_en;
  logic unused_pwdata;

  assign wr_en         = psel_i & penable_i & pwrite_i;
  assign rd_en         = psel_i & penable_i & ~pwrite_i;
  assign unused_pwdata = ^pwdata_i;

  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign head     = mem[rd_ptr];
  assign push_req = wr_en && (paddr_i == A_TXDATA);
  assign push     = push_req && !full;
  assign ovf_set  = push_req && full;
  assign sh_shift = sh >> 1;

  // Register file writes; overflow wins over a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!rst_) begin
      txen   <= 1'b0;
      par    <= '0;
      stop2  <= 1'b0;
      div    <= '0;
      ovf    <= 1'b0;
      lvl_ie <= 1'b0;
      ovf_ie <= 1'b0;
      thresh <= '0;
    end else begin
      if (wr_en && paddr_i == A_CTRL) begin
        txen  <= pwdata_i[0];
        par   <= pwdata_i[2:1];
        stop2 <= pwdata_i[3];
      end
      if (wr_en && paddr_i == A_BAUD)
        div <= pwdata_i[DIV_W-1:0];
      if (wr_en && paddr_i == A_INTCFG) begin
        lvl_ie <= pwdata_i[0];
        ovf_ie <= pwdata_i[1];
        thresh <= pwdata_i[15:8];
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (wr_en && paddr_i == A_STATUS && pwdata_i[3])
        ovf <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO storage needs no reset: occupancy alone defines valid entries
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pwdata_i[DATA_BITS-1:0];
  end

  // Registered interrupt
  always_ff @(posedge clk) begin
    if (!rst_)
      int_r <= 1'b0;
    else
      int_r <= (lvl_ie && (32'(level) <= 32'(thresh))) || (ovf_ie && ovf);
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state     <= IDLE;
      cnt       <= '0;
      f_div     <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      f_par_en  <= 1'b0;
      f_par_bit <= 1'b0;
      f_stop2   <= 1'b0;
      stop_cnt  <= 1'b0;
      utxd      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      f_div     <= f_div_n;
      bit_cnt   <= bit_cnt_n;
      sh        <= sh_n;
      f_par_en  <= f_par_en_n;
      f_par_bit <= f_par_bit_n;
      f_stop2   <= f_stop2_n;
      stop_cnt  <= stop_cnt_n;
      utxd      <= utxd_n;
    end
  end

  // Next-state logic; the line value is computed one cycle ahead so that
  // utxd_o is a flop output changing only at bit boundaries
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    f_div_n     = f_div;
    bit_cnt_n   = bit_cnt;
    sh_n        = sh;
    f_par_en_n  = f_par_en;
    f_par_bit_n = f_par_bit;
    f_stop2_n   = f_stop2;
    stop_cnt_n  = stop_cnt;
    utxd_n      = utxd;
    load        = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        utxd_n = 1'b1;
        if (txen && !empty) load = 1'b1;
      end
      START: begin
        if (cnt == f_div) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          utxd_n    = sh[0];
          state_n   = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == f_div) begin
          cnt_n = '0;
          if (bit_cnt == LAST_BIT) begin
            if (f_par_en) begin
              utxd_n  = f_par_bit;
              state_n = PARITY;
            end else begin
              utxd_n     = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = STOP;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            sh_n      = sh_shift;
            utxd_n    = sh_shift[0];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (cnt == f_div) begin
          cnt_n      = '0;
          utxd_n     = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == f_div) begin
          cnt_n = '0;
          if (f_stop2 && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else if (txen && !empty) begin
            load = 1'b1;
          end else begin
            utxd_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        utxd_n  = 1'b1;
        state_n = IDLE;
      end
    endcase
    if (load) begin
      pop         = 1'b1;
      sh_n        = head;
      f_par_en_n  = (par == 2'b01) || (par == 2'b10);
      f_par_bit_n = (^head) ^ (par == 2'b10);
      f_stop2_n   = stop2;
      f_div_n     = div;
      cnt_n       = '0;
      utxd_n      = 1'b0;
      state_n     = START;
    end
  end

  // APB read mux
  always_comb begin
    prdata_o = '0;
    if (rd_en) begin
      case (paddr_i)
        A_CTRL:   prdata_o[3:0] = {stop2, par, txen};
        A_BAUD:   prdata_o[DIV_W-1:0] = div;
        A_STATUS: begin
          prdata_o[0]        = full;
          prdata_o[1]        = empty;
          prdata_o[2]        = (state != IDLE);
          prdata_o[3]        = ovf;
          prdata_o[8 +: AW+1] = level;
        end
        A_INTCFG: begin
          prdata_o[0]    = lvl_ie;
          prdata_o[1]    = ovf_ie;
          prdata_o[15:8] = thresh;
        end
        default:  prdata_o = '0;
      endcase
    end
  end

  assign utxd_o     = utxd;
  assign uart_int_o = int_r;

endmodule

// File: tb/tb_apb_uart_tx_fifo.sv
// Bench for apb_uart_tx_fifo: register table, serial-line scoreboard and
// hand-written sequences for the multi-cycle corner cases.
module tb_apb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        psel, penable, pwrite;
  logic        utxd, uart_int;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [8:0]  data;
    int          div;
    logic [1:0]  par;
    logic        stop2;
  } frame_t;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    string       name;
  } reg_vec_t;

  frame_t   sb[$];
  reg_vec_t tbl[$];

  bit mon_busy = 1'b0;
  int frames_seen = 0;
  int first_start_cyc = 0;
  int last_start_cyc = 0;

  apb_uart_tx_fifo #(
    .DATA_BITS (8),
    .FIFO_DEPTH(16),
    .DIV_W     (16),
    .ADDR_W    (8)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .utxd_o    (utxd),
    .uart_int_o(uart_int)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic expect_frame(input logic [8:0] d, input int dv, input logic [1:0] p, input logic s2);
    frame_t f;
    f.data = d; f.div = dv; f.par = p; f.stop2 = s2;
    sb.push_back(f);
  endtask

  task automatic push_byte(input logic [7:0] d, input int dv, input logic [1:0] p, input logic s2);
    expect_frame({1'b0, d}, dv, p, s2);
    apb_write(8'h00, {24'h0, d});
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((sb.size() != 0 || mon_busy) && k < limit) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1;
    if (k >= limit) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: %0d frames still pending after %0d cycles, expected 0", sb.size(), limit);
      sb.delete();
    end
  endtask

  task automatic add_vec(input logic wr, input logic [7:0] a, input logic [31:0] d, input string nm);
    reg_vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.name = nm;
    tbl.push_back(v);
  endtask

  // Serial-line receiver: checks every clock of each frame against the
  // frame expected at the head of the scoreboard
  initial begin : uart_monitor
    frame_t      e;
    logic [15:0] expw, got;
    int          nb, bad;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_ === 1'b1 && utxd === 1'b0) begin
        mon_busy = 1'b1;
        if (frames_seen == 0) first_start_cyc = cyc;
        last_start_cyc = cyc;
        frames_seen++;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected idle line", cyc);
          for (int k = 0; k < 5000 && utxd !== 1'b1; k++) @(negedge clk);
        end else begin
          e = sb.pop_front();
          expw = '0; nb = 0;
          expw[nb] = 1'b0; nb++;
          for (int i = 0; i < 8; i++) begin expw[nb] = e.data[i]; nb++; end
          if (e.par == 2'b01 || e.par == 2'b10) begin
            expw[nb] = (^e.data[7:0]) ^ (e.par == 2'b10);
            nb++;
          end
          expw[nb] = 1'b1; nb++;
          if (e.stop2) begin expw[nb] = 1'b1; nb++; end
          got = '0; bad = 0; aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c <= e.div && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_ !== 1'b1) begin
                aborted = 1'b1;
              end else begin
                if (c == 0) got[b] = utxd;
                if (utxd !== expw[b]) bad++;
              end
            end
          end
          if (!aborted) begin
            n_vec++;
            if (bad != 0 || got !== expw) begin
              n_err++;
              $display("FAIL frame: got bits 0x%0h with %0d off-bit samples, expected bits 0x%0h with 0",
                       got, bad, expw);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    logic [31:0] rd;
    logic [7:0]  d;
    int          lvl_at, int_at;

    rst_ = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_utxd", 32'(utxd), 32'h1);
    check("rst_int", 32'(uart_int), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    rst_ = 1'b1;

    // Register table: reset values, read-back masks, unmapped space, W1C
    add_vec(1'b0, 8'h04, 32'h0,        "ctrl_rst");
    add_vec(1'b0, 8'h08, 32'h0,        "baud_rst");
    add_vec(1'b0, 8'h10, 32'h0,        "intcfg_rst");
    add_vec(1'b0, 8'h0C, 32'h2,        "status_rst");
    add_vec(1'b0, 8'h00, 32'h0,        "txdata_reads0");
    add_vec(1'b1, 8'h04, 32'hFFFFFFFE, "");
    add_vec(1'b0, 8'h04, 32'hE,        "ctrl_mask");
    add_vec(1'b1, 8'h08, 32'hFFFFFFFF, "");
    add_vec(1'b0, 8'h08, 32'hFFFF,     "baud_mask");
    add_vec(1'b1, 8'h10, 32'hFFFFFFFF, "");
    add_vec(1'b0, 8'h10, 32'hFF03,     "intcfg_mask");
    add_vec(1'b1, 8'h14, 32'hFFFFFFFF, "");
    add_vec(1'b0, 8'h14, 32'h0,        "unmapped_read");
    add_vec(1'b1, 8'h0C, 32'hFFFFFFFF, "");
    add_vec(1'b0, 8'h0C, 32'h2,        "status_w1c_noop");
    add_vec(1'b1, 8'h04, 32'h0,        "");
    add_vec(1'b1, 8'h08, 32'h0,        "");
    add_vec(1'b1, 8'h10, 32'h0,        "");
    add_vec(1'b0, 8'h10, 32'h0,        "intcfg_cleared");
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        apb_write(tbl[i].addr, tbl[i].data);
      end else begin
        apb_read(tbl[i].addr, rd);
        check(tbl[i].name, rd, tbl[i].data);
      end
    end
    check("int_after_table", 32'(uart_int), 32'h0);

    // Basic 8N1 frame, DIV=3
    apb_write(8'h08, 32'd3);
    apb_write(8'h04, 32'h1);
    push_byte(8'hA5, 3, 2'b00, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    apb_read(8'h0C, rd);
    check("busy_midframe", rd, 32'h6);
    wait_idle(200);
    apb_read(8'h0C, rd);
    check("idle_after_frame", rd, 32'h2);

    // Parity and stop modes, DIV=1
    apb_write(8'h08, 32'd1);
    apb_write(8'h04, 32'hB);
    push_byte(8'h07, 1, 2'b01, 1'b1);
    wait_idle(200);
    apb_write(8'h04, 32'h5);
    push_byte(8'h07, 1, 2'b10, 1'b0);
    wait_idle(200);
    apb_write(8'h04, 32'h7);
    push_byte(8'h3C, 1, 2'b11, 1'b0);
    wait_idle(200);

    // Overflow, W1C, then back-to-back drain
    apb_write(8'h04, 32'h0);
    for (int i = 0; i < 17; i++) begin
      d = 8'((i * 37 + 5) & 8'hFF);
      if (i < 16) expect_frame({1'b0, d}, 1, 2'b00, 1'b0);
      apb_write(8'h00, {24'h0, d});
    end
    apb_read(8'h0C, rd);
    check("ovf_full_status", rd, 32'h1009);
    apb_write(8'h0C, 32'h8);
    apb_read(8'h0C, rd);
    check("ovf_w1c", rd, 32'h1001);
    frames_seen = 0;
    apb_write(8'h04, 32'h1);
    wait_idle(1000);
    check("frames_after_ovf", 32'(frames_seen), 32'd16);
    check("back_to_back_span", 32'(last_start_cyc - first_start_cyc), 32'd300);
    apb_read(8'h0C, rd);
    check("empty_after_drain", rd, 32'h2);

    // Level interrupt
    apb_write(8'h04, 32'h0);
    for (int i = 0; i < 4; i++) push_byte(8'(8'h11 * (i + 1)), 1, 2'b00, 1'b0);
    apb_write(8'h10, 32'h0201);
    @(posedge clk); #1;
    check("int_low_level4", 32'(uart_int), 32'h0);
    apb_write(8'h04, 32'h1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h0C;
    lvl_at = -1; int_at = -1;
    for (int k = 0; k < 300 && (lvl_at < 0 || int_at < 0); k++) begin
      @(negedge clk);
      if (lvl_at < 0 && prdata[16:8] == 9'd2) lvl_at = k;
      if (int_at < 0 && uart_int === 1'b1) int_at = k;
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("int_rise_delay", 32'(int_at - lvl_at), 32'd1);
    apb_write(8'h10, 32'h0200);
    check("int_hold_one_cycle", 32'(uart_int), 32'h1);
    @(posedge clk); #1;
    check("int_clear_lvl_ie", 32'(uart_int), 32'h0);
    wait_idle(400);

    // Baud change mid-frame applies to the next frame only
    apb_write(8'h04, 32'h0);
    apb_write(8'h08, 32'd3);
    push_byte(8'h3C, 3, 2'b00, 1'b0);
    push_byte(8'h81, 7, 2'b00, 1'b0);
    apb_write(8'h04, 32'h1);
    repeat (12) @(posedge clk);
    #1;
    apb_write(8'h08, 32'd7);
    wait_idle(400);

    // TXEN cleared mid-frame: frame completes, rest stays queued
    apb_write(8'h04, 32'h0);
    apb_write(8'h08, 32'd3);
    push_byte(8'h5A, 3, 2'b00, 1'b0);
    apb_write(8'h00, 32'hC3);
    apb_write(8'h00, 32'h69);
    apb_write(8'h04, 32'h1);
    repeat (8) @(posedge clk);
    #1;
    apb_write(8'h04, 32'h0);
    wait_idle(200);
    repeat (50) @(posedge clk);
    #1;
    apb_read(8'h0C, rd);
    check("txen_off_retained", rd, 32'h200);
    expect_frame(9'h0C3, 3, 2'b00, 1'b0);
    expect_frame(9'h069, 3, 2'b00, 1'b0);
    apb_write(8'h04, 32'h1);
    wait_idle(400);

    // Reset during the data bits
    apb_write(8'h10, 32'h0201);
    push_byte(8'h00, 3, 2'b00, 1'b0);
    push_byte(8'h00, 3, 2'b00, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_line", 32'(utxd), 32'h0);
    check("pre_reset_int", 32'(uart_int), 32'h1);
    rst_ = 1'b0;
    @(posedge clk); #1;
    check("reset_line_high", 32'(utxd), 32'h1);
    check("reset_int_low", 32'(uart_int), 32'h0);
    rst_ = 1'b1;
    sb.delete();
    apb_read(8'h0C, rd);
    check("reset_status", rd, 32'h2);
    apb_read(8'h04, rd);
    check("reset_ctrl", rd, 32'h0);
    apb_read(8'h08, rd);
    check("reset_baud", rd, 32'h0);
    apb_read(8'h10, rd);
    check("reset_intcfg", rd, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("idle_line_after_reset", 32'(utxd), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
